ps2_kbd_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_evt_fifo.sv | 42 ++++
 rtl/ps2_kbd_rx.sv | 164 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM state,
// prefix scancodes and the decoded key event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO of key events. Pointers carry one extra wrap bit
// so that full and empty are told apart without a separate occupancy counter.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  ps2_evt_t    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw lines, frames 11-bit words,
// decodes E0/F0 prefixes into key events and queues them for a consumer.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_dat,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_brk,
  output logic             evt_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  ps2_state_t      state;
  ps2_state_t      state_next;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            err_now;
  logic            byte_ok;

  logic            ext_flag;
  logic            brk_flag;
  logic            evt_gen;
  ps2_evt_t        new_evt;
  ps2_evt_t        head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  always_comb begin
    state_next = state;
    err_now    = 1'b0;
    byte_ok    = 1'b0;
    case (state)
      IDLE:    if (fall && !dat_s) state_next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fall) state_next = STOP;
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if ((^shreg ^ par_bit) && dat_s) byte_ok = 1'b1;
          else                             err_now = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A stalled partial frame is abandoned; a fall in the same cycle wins.
    if (state != IDLE && !fall && to_cnt == TO_LAST) begin
      state_next = IDLE;
      err_now    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= err_now;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && fall) begin
        shreg   <= {dat_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && fall) par_bit <= dat_s;
      to_cnt <= (state_next == IDLE || fall) ? '0 : to_cnt + TO_W'(1);
    end
  end

  assign evt_gen = byte_ok && (shreg != PS2_EXT) && (shreg != PS2_BRK);
  assign new_evt = {ext_flag, brk_flag, shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      press_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (err_now || evt_gen) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == PS2_EXT) ext_flag <= 1'b1;
        if (shreg == PS2_BRK) brk_flag <= 1'b1;
      end
      if (evt_gen && brk_flag) press_count <= press_count + CNT_W'(1);
      if (evt_gen && fifo_full && !pop) overflow <= 1'b1;
      else if (clr_overflow)            overflow <= 1'b0;
    end
  end

  // Output handshake: the head event transfers on a clk edge where
  // evt_valid && evt_ready; while evt_valid && !evt_ready the head is held.
  assign pop  = evt_valid && evt_ready;
  assign push = evt_gen && (!fifo_full || pop);

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (new_evt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_brk   = evt_valid ? head.brk  : 1'b0;
  assign evt_ext   = evt_valid ? head.ext  : 1'b0;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: drives PS/2 frames and compares decoded events,
// counters and flags against a byte-level model of the keyboard protocol.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TOUT  = 100;
  localparam int SYNC  = 2;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [7:0]    evt_code;
  logic          evt_brk;
  logic          evt_ext;
  logic [CW-1:0] press_count;
  logic          frame_err;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [9:0]    exp_q[$];
  logic [9:0]    got_q[$];
  logic          m_ext = 1'b0;
  logic          m_brk = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_ovf = 1'b0;
  int            m_fill = 0;
  bit            hold_mode = 1'b0;
  int            err_exp = 0;
  int            err_cnt = 0;
  int            chk_from = 0;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TOUT),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_brk      (evt_brk),
    .evt_ext      (evt_ext),
    .press_count  (press_count),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Monitor: records every accepted event and every frame_err pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (evt_valid && evt_ready) got_q.push_back({evt_ext, evt_brk, evt_code});
      if (frame_err) err_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-level protocol model: prefixes set flags, errors clear them,
  // any other byte becomes an event that fits in the FIFO or is dropped.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      err_exp++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (m_brk) m_cnt = m_cnt + 1'b1;
      if (hold_mode && m_fill == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back({m_ext, m_brk, b});
        if (hold_mode) m_fill++;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Driver: one 11-bit frame, data changes while ps2_clk is high.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    int half;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      half = $urandom_range(4, 10);
      ps2_dat = bits[i];
      wait_clk(half);
      ps2_clk = 1'b0;
      wait_clk(half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_clk(12);
    model_byte(b, bad_par | bad_stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++; if (evt_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", evt_code); end
    checks++; if (evt_brk !== 1'b0) begin errors++; $display("FAIL reset_brk: got %b expected 0", evt_brk); end
    checks++; if (evt_ext !== 1'b0) begin errors++; $display("FAIL reset_ext: got %b expected 0", evt_ext); end
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL reset_count: got %0d expected %0d", press_count, m_cnt); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL reset_ovf: got %b expected %b", overflow, m_ovf); end
  endtask

  task automatic test_make;
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL make_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL make_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL make_count: got %0d expected %0d", press_count, m_cnt); end
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL make_err: got %0d expected %0d", err_cnt, err_exp); end
  endtask

  task automatic test_release;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rel_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rel_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL rel_count: got %0d expected %0d", press_count, m_cnt); end
  endtask

  task automatic test_ext_release;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ext_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ext_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL ext_count: got %0d expected %0d", press_count, m_cnt); end
  endtask

  task automatic test_bad_frames;
    send_frame(8'h1C, 1'b1, 1'b0);
    wait_clk(4);
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL badpar_err: got %0d expected %0d", err_cnt, err_exp); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL badpar_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    // A broken frame after F0 must cancel the pending release.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL badstop_err: got %0d expected %0d", err_cnt, err_exp); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL badflag_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL badflag_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL badflag_count: got %0d expected %0d", press_count, m_cnt); end
  endtask

  task automatic test_timeout;
    logic [4:0] pb;
    bit seen;
    int lat;
    send_frame(8'hE0, 1'b0, 1'b0);
    pb = 5'b10110;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      ps2_dat = pb[i];
      wait_clk(5);
      ps2_clk = 1'b0;
      if (i < 4) begin
        wait_clk(5);
        ps2_clk = 1'b1;
      end
    end
    // 100 idle cycles after the detected fall, plus synchronizer and output register.
    for (int i = 1; i <= 300 && !seen; i++) begin
      wait_clk(1);
      if (i == 5) begin
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
      end
      if (frame_err) begin
        seen = 1'b1;
        lat = i;
      end
    end
    model_byte(8'h00, 1'b1);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_seen: got no pulse expected pulse within 300 cycles"); end
    checks++; if (seen && (lat < TOUT + SYNC || lat > TOUT + SYNC + 2)) begin errors++; $display("FAIL timeout_lat: got %0d expected %0d", lat, TOUT + SYNC + 1); end
    wait_clk(3);
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, err_exp); end
    send_frame(8'h2B, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
  endtask

  task automatic test_overflow;
    evt_ready = 1'b0;
    hold_mode = 1'b1;
    m_fill = 0;
    for (int i = 0; i < 9; i++) send_frame(8'h16 + 8'(i), 1'b0, 1'b0);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, m_ovf); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", evt_valid); end
    for (int i = 0; i < 4; i++) begin
      wait_clk($urandom_range(1, 5));
      checks++; if ({evt_ext, evt_brk, evt_code} !== exp_q[chk_from]) begin errors++; $display("FAIL ovf_hold: got %h expected %h", {evt_ext, evt_brk, evt_code}, exp_q[chk_from]); end
    end
    evt_ready = 1'b1;
    wait_clk(15);
    hold_mode = 1'b0;
    m_fill = 0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", evt_valid); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", overflow, m_ovf); end
    clr_overflow = 1'b1;
    wait_clk(1);
    clr_overflow = 1'b0;
    m_ovf = 1'b0;
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_clear: got %b expected %b", overflow, m_ovf); end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] pb;
    send_frame(8'hF0, 1'b0, 1'b0);
    pb = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      ps2_dat = pb[i];
      wait_clk(5);
      ps2_clk = 1'b0;
      wait_clk(5);
      ps2_clk = 1'b1;
    end
    rst = 1'b1;
    ps2_dat = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_cnt = '0;
    m_ovf = 1'b0;
    wait_clk(3);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", evt_valid); end
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", press_count, m_cnt); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", frame_err); end
    checks++; if ({evt_ext, evt_brk, evt_code} !== 10'h000) begin errors++; $display("FAIL rstmid_evt: got %h expected 000", {evt_ext, evt_brk, evt_code}); end
    rst = 1'b0;
    wait_clk(120);
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL rstmid_noerr: got %0d expected %0d", err_cnt, err_exp); end
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clk(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_next[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
  endtask

  task automatic test_random;
    logic [7:0] b;
    int k;
    bit bp, bs;
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2)      b = 8'hE0;
      else if (k < 4) b = 8'hF0;
      else            b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 11) == 0);
      bs = !bp && ($urandom_range(0, 11) == 0);
      evt_ready = (n % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(b, bp, bs);
    end
    evt_ready = 1'b1;
    wait_clk(20);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_num: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_from; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    chk_from = exp_q.size();
    checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL rand_count: got %0d expected %0d", press_count, m_cnt); end
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL rand_err: got %0d expected %0d", err_cnt, err_exp); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf); end
  endtask

  initial begin
    test_reset;
    test_make;
    test_release;
    test_ext_release;
    test_bad_frames;
    test_timeout;
    test_overflow;
    test_reset_mid_frame;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
